// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between fetch and decode.
// Packets from fetch are queued in program order and the oldest one is offered
// to decode. A branch mispredict from retire empties the queue.
// Optional macro FETCH_QUEUE_ASSERT_EN compiles in simulation assertions
// (overflow, SIMID ordering on dequeue, occupancy bound).
//
// Handshake: fetch -> queue: a packet transfers on a cycle with valid_fe1=1 and
// fq_full_fe1=0 (fq_full_fe1 acts as an inverted, registered ready).
// queue -> decode: the head transfers on a cycle with valid_fq1=1 and stall=0
// (stall is an inverted ready). br_mispred_rb1 cancels both transfers.

package fetch_queue_pkg;
   typedef struct packed {
      logic [15:0] simid;
      logic [31:0] pc;
      logic [31:0] instr;
   } t_instr_pkt;
endpackage

module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       valid_fe1,
   input  t_instr_pkt                 instr_fe1,
   output logic                       fq_full_fe1,
   output logic                       valid_fq1,
   output t_instr_pkt                 instr_fq1,
   input  logic                       stall,
   input  logic                       br_mispred_rb1,
   output logic [$clog2(DEPTH+1)-1:0] fq_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   t_instr_pkt      entry [DEPTH];
   logic [PW-1:0]   wp;
   logic [PW-1:0]   rp;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic            enq;
   logic            deq;

   // Status outputs come from registers only; head is a direct read of storage.
   assign fq_full_fe1 = (count == CW'(DEPTH));
   assign valid_fq1   = (count != '0);
   assign instr_fq1   = entry[rp];
   assign fq_count    = count;

   // A flush cancels both the incoming packet and the decode transfer.
   assign enq = valid_fe1 & ~fq_full_fe1 & ~br_mispred_rb1;
   assign deq = valid_fq1 & ~stall & ~br_mispred_rb1;

   // Occupancy update: simultaneous enq and deq leave the count unchanged.
   always_comb begin
      count_next = count;
      if (enq && !deq) begin
         count_next = count + CW'(1);
      end else if (!enq && deq) begin
         count_next = count - CW'(1);
      end
   end

   // Packet storage; contents survive flush and reset (only pointers move).
   always_ff @(posedge clk) begin
      if (enq) begin
         entry[wp] <= instr_fe1;
      end
   end

   // Pointers and occupancy, cleared by reset or flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (br_mispred_rb1) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (enq) wp <= wp + PW'(1);
         if (deq) rp <= rp + PW'(1);
         count <= count_next;
      end
   end

`ifdef FETCH_QUEUE_ASSERT_EN
   logic        have_last;
   logic [15:0] last_simid;

   // Fetch must respect the full indication.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(valid_fe1 && fq_full_fe1 && !br_mispred_rb1))
            else $error("fetch_queue overflow: valid_fe1 while full");
         assert (count <= CW'(DEPTH))
            else $error("fetch_queue count %0d exceeds DEPTH", count);
      end
   end

   // Dequeued SIMIDs must increase strictly between flushes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         have_last  <= 1'b0;
         last_simid <= '0;
      end else if (br_mispred_rb1) begin
         have_last  <= 1'b0;
      end else if (deq) begin
         assert (!have_last || (instr_fq1.simid > last_simid))
            else $error("fetch_queue SIMID order: %0d after %0d", instr_fq1.simid, last_simid);
         have_last  <= 1'b1;
         last_simid <= instr_fq1.simid;
      end
   end
`else
   // Assertions disabled; overflow packets are silently dropped.
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue (DEPTH=4).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 4;

   logic       clk;
   logic       reset;
   logic       valid_fe1;
   t_instr_pkt instr_fe1;
   logic       fq_full_fe1;
   logic       valid_fq1;
   t_instr_pkt instr_fq1;
   logic       stall;
   logic       br_mispred_rb1;
   logic [$clog2(DEPTH+1)-1:0] fq_count;

   int total = 0;
   int bad   = 0;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .valid_fe1      (valid_fe1),
      .instr_fe1      (instr_fe1),
      .fq_full_fe1    (fq_full_fe1),
      .valid_fq1      (valid_fq1),
      .instr_fq1      (instr_fq1),
      .stall          (stall),
      .br_mispred_rb1 (br_mispred_rb1),
      .fq_count       (fq_count)
   );

   // 10ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic t_instr_pkt mk(input int simid);
      t_instr_pkt p;
      p.simid = 16'(simid);
      p.pc    = 32'(simid * 4);
      p.instr = 32'h1300_0000 | 32'(simid);
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic v, input int cnt, input logic full);
      chk({tag, ".valid"}, 32'(valid_fq1), 32'(v));
      chk({tag, ".count"}, 32'(fq_count), 32'(cnt));
      chk({tag, ".full"}, 32'(fq_full_fe1), 32'(full));
   endtask

   task automatic chk_head(input string tag, input int simid);
      chk({tag, ".simid"}, 32'(instr_fq1.simid), 32'(simid));
      chk({tag, ".instr"}, instr_fq1.instr, 32'h1300_0000 | 32'(simid));
   endtask

   initial begin
      reset          = 1'b1;
      valid_fe1      = 1'b0;
      instr_fe1      = mk(0);
      stall          = 1'b0;
      br_mispred_rb1 = 1'b0;
      tick();
      chk_state("reset", 1'b0, 0, 1'b0);
      tick();
      reset = 1'b0;
      tick();
      chk_state("idle", 1'b0, 0, 1'b0);

      // Single packet: visible one cycle after enqueue, gone the next.
      valid_fe1 = 1'b1; instr_fe1 = mk(5);
      tick();
      valid_fe1 = 1'b0;
      chk_state("single.after_enq", 1'b1, 1, 1'b0);
      chk_head("single.head", 5);
      tick();
      chk_state("single.after_deq", 1'b0, 0, 1'b0);

      // Fill under stall, then drain in order.
      stall = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         valid_fe1 = 1'b1; instr_fe1 = mk(k);
         tick();
         chk_head($sformatf("fill.head_stable%0d", k), 1);
         chk_state($sformatf("fill.k%0d", k), 1'b1, k, (k == 4));
      end
      valid_fe1 = 1'b0;
      tick();
      chk_state("fill.stalled_full", 1'b1, 4, 1'b1);
      chk_head("fill.stalled_head", 1);
      stall = 1'b0;
      tick();
      chk_state("drain.first", 1'b1, 3, 1'b0);
      chk_head("drain.h2", 2);
      tick();
      chk_head("drain.h3", 3);
      tick();
      chk_head("drain.h4", 4);
      chk_state("drain.last", 1'b1, 1, 1'b0);
      tick();
      chk_state("drain.empty", 1'b0, 0, 1'b0);

      // Full queue: push while full (stalled and unstalled) is dropped.
      stall = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         valid_fe1 = 1'b1; instr_fe1 = mk(k);
         tick();
      end
      chk_state("ovf.full", 1'b1, 4, 1'b1);
      stall = 1'b0; valid_fe1 = 1'b1; instr_fe1 = mk(9);
      tick();
      valid_fe1 = 1'b0;
      chk_state("ovf.after", 1'b1, 3, 1'b0);
      chk_head("ovf.h2", 2);
      tick();
      chk_head("ovf.h3", 3);
      tick();
      chk_head("ovf.h4", 4);
      tick();
      chk_state("ovf.empty", 1'b0, 0, 1'b0);

      // Flush with 3 queued and a same-cycle enqueue.
      stall = 1'b1;
      for (int k = 11; k <= 13; k++) begin
         valid_fe1 = 1'b1; instr_fe1 = mk(k);
         tick();
      end
      chk_state("flush.before", 1'b1, 3, 1'b0);
      chk_head("flush.head", 11);
      br_mispred_rb1 = 1'b1; valid_fe1 = 1'b1; instr_fe1 = mk(14);
      tick();
      br_mispred_rb1 = 1'b0; valid_fe1 = 1'b0;
      chk_state("flush.after", 1'b0, 0, 1'b0);
      stall = 1'b0; valid_fe1 = 1'b1; instr_fe1 = mk(20);
      tick();
      valid_fe1 = 1'b0;
      chk_state("flush.refill", 1'b1, 1, 1'b0);
      chk_head("flush.h20", 20);
      tick();
      chk_state("flush.empty", 1'b0, 0, 1'b0);

      // Streaming across pointer wrap: count stays at 1.
      for (int k = 1; k <= 10; k++) begin
         valid_fe1 = 1'b1; instr_fe1 = mk(k);
         tick();
         chk_head($sformatf("stream.h%0d", k), k);
         chk($sformatf("stream.count%0d", k), 32'(fq_count), 32'd1);
      end
      valid_fe1 = 1'b0;
      tick();
      chk_state("stream.empty", 1'b0, 0, 1'b0);

      // Asynchronous reset mid-cycle with 2 entries.
      stall = 1'b1;
      for (int k = 30; k <= 31; k++) begin
         valid_fe1 = 1'b1; instr_fe1 = mk(k);
         tick();
      end
      valid_fe1 = 1'b0;
      chk_state("areset.before", 1'b1, 2, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk_state("areset.async", 1'b0, 0, 1'b0);
      tick();
      reset = 1'b0; stall = 1'b0;
      valid_fe1 = 1'b1; instr_fe1 = mk(40);
      tick();
      valid_fe1 = 1'b0;
      chk_state("areset.refill", 1'b1, 1, 1'b0);
      chk_head("areset.h40", 40);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling FIFO between the fetch stage and decode. Captures instruction packets produced by fetch (`valid_fe1`/`instr_fe1`), holds them while decode is stalled, and presents the oldest packet to decode in program order. Gives fetch a registered full indication for backpressure. Empties completely on a branch mispredict from retire.

## Interface
Parameters:
- `DEPTH`, default 4: number of packet entries; power of two, minimum 2.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `valid_fe1`  in  1  fetch presents a packet this cycle.
- `instr_fe1`  in  $bits(t_instr_pkt)  packet from fetch (includes SIMID).
- `fq_full_fe1`  out  1  queue holds DEPTH entries; fetch must not assert `valid_fe1`.
- `valid_fq1`  out  1  head entry valid, offered to decode.
- `instr_fq1`  out  $bits(t_instr_pkt)  head packet.
- `stall`  in  1  decode cannot accept this cycle; head is held.
- `br_mispred_rb1`  in  1  flush; discard all entries and any same-cycle enqueue.
- `fq_count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage: DEPTH-entry array, write pointer `wp`, read pointer `rp`, both $clog2(DEPTH) bits, wrap modulo DEPTH; `count` tracked separately ($clog2(DEPTH+1) bits).
- Enqueue: `enq = valid_fe1 & ~fq_full_fe1 & ~br_mispred_rb1`. Writes `instr_fe1` to entry `wp`; `wp` increments.
- Dequeue: `deq = valid_fq1 & ~stall & ~br_mispred_rb1`. `rp` increments.
- `count_next = count + enq - deq`; simultaneous enq and deq leave count unchanged.
- Output: `valid_fq1 = (count != 0)`; `instr_fq1 = entry[rp]` (combinational read of registered storage, no logic from `valid_fe1`).
- Full: `fq_full_fe1 = (count == DEPTH)`, derived from registers only. When full, an asserted `valid_fe1` is dropped even if a dequeue occurs that cycle.
- Empty: `valid_fq1 = 0`; `instr_fq1` is don't-care (holds stale entry). Dequeue ignored.
- Flush: `br_mispred_rb1` high sets `wp = rp = 0`, `count = 0` at next edge; overrides enq and deq in the same cycle. Entry contents are not cleared.
- Stall: while `stall` high, `valid_fq1`/`instr_fq1` are stable unless a flush occurs.
- Reset (any time, asynchronous): `wp = rp = 0`, `count = 0`; outputs immediately `valid_fq1 = 0`, `fq_full_fe1 = 0`, `fq_count = 0`. In-flight packets are lost.
- No state machine beyond pointers/count; ordering is strict FIFO.

## Timing
- Enqueue-to-output latency: 1 cycle. Packet enqueued at edge N is visible on `instr_fq1` during cycle N+1 (when the queue is empty). No same-cycle bypass.
- Dequeue takes effect at the edge: next entry (if any) appears the cycle after the accepting cycle.
- Throughput: 1 enqueue + 1 dequeue per cycle sustained.
- `fq_full_fe1` asserts the cycle after the DEPTH-th enqueue; deasserts the cycle after the first dequeue from full.
- Flush: `valid_fq1 = 0` the cycle after `br_mispred_rb1` is sampled high.

## Configuration
- `FETCH_QUEUE_ASSERT_EN` defined: simulation assertions compiled in — (a) `valid_fe1 & fq_full_fe1 & ~br_mispred_rb1` is an error (overflow); (b) `instr_fq1.SIMID` of consecutive dequeues, absent an intervening flush, is strictly increasing; (c) `count <= DEPTH` always.
- Undefined: no assertion logic; functional behaviour identical (overflow packets silently dropped).

## Test plan
- Reset then single enqueue SIMID=5 with `stall=0` -> `valid_fq1=1`, `instr_fq1.SIMID=5` exactly one cycle later, then `valid_fq1=0`.
- DEPTH=4, `stall=1`, enqueue SIMIDs 1..4 back-to-back -> `fq_full_fe1=1` after 4th edge, `fq_count=4`; release stall -> SIMIDs 1,2,3,4 on consecutive cycles, full drops after first dequeue.
- Full queue, `valid_fe1=1` (SIMID 9) with simultaneous dequeue -> SIMID 9 dropped, `fq_count=3`, output order continues 2,3,4; assertion fires when `FETCH_QUEUE_ASSERT_EN` set.
- 3 entries queued, `br_mispred_rb1=1` with `valid_fe1=1` same cycle -> next cycle `fq_count=0`, `valid_fq1=0`; following enqueue SIMID 20 appears one cycle later.
- Continuous enq/deq for 10 cycles across pointer wrap (SIMID 1..10, stall=0) -> output SIMIDs 1..10 in order, `fq_count` constant at 1.
- Assert `reset` asynchronously mid-stream with 2 entries -> `valid_fq1=0`, `fq_count=0` before the next clock edge.
